// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder
//
// Packs an RV32I instruction word from separate fields: opcode, funct3,
// funct7, rd, rs1, rs2 and a full-width immediate. The immediate arrives as a
// plain 32-bit value and this block scatters it into the format-specific bit
// positions. Illegal opcodes, out-of-range immediates and illegal field
// combinations raise out_error.
//
// Optional feature, macro RV32I_ENCODER_LI_EXPAND_EN:
//   When defined, in_li requests the "li rd, imm" pseudo-instruction. It
//   expands to ADDI, LUI, or LUI followed by ADDI. With the macro undefined,
//   in_li is ignored and the LI_HI state does not exist.
//
// Ports:
//   clk, rst              rising-edge clock; synchronous active-high reset
//   in_valid / in_ready   field bundle handshake
//   in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, in_li
//   out_valid / out_ready instruction word handshake
//   out_inst              encoded word (zero on error when ZERO_ON_ERROR=1)
//   out_error             encode error for this word
//   out_last              last word of a sequence (0 only on the LUI of a
//                         two-word LI)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid never depends on ready. While out_valid && !out_ready, out_inst,
// out_error and out_last stay stable. in_ready is high only when the output
// register is free, or is being emptied in the same cycle, and no LI
// expansion is mid-way.
module rv32i_inst_encoder #(
  parameter bit ZERO_ON_ERROR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_li,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_error,
  output logic        out_last
);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  // IDLE: output register empty. HOLD: one word pending on the output.
  // LI_HI: the LUI of an LI pair is pending and the ADDI is parked in addi_q.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1
`ifdef RV32I_ENCODER_LI_EXPAND_EN
    , LI_HI = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_error_q, out_error_d;
  logic        out_last_q, out_last_d;

  logic        in_fire;
  logic        fits12, fits13, fits21;
  logic [31:0] enc_inst;
  logic        enc_err;
  logic [31:0] enc_word;

  assign out_valid = (state_q != IDLE);
  assign out_inst  = out_inst_q;
  assign out_error = out_error_q;
  assign out_last  = out_last_q;

  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign in_fire  = in_valid && in_ready;

  // Each immediate must be the sign extension of its encodable width.
  assign fits12 = (in_imm == {{20{in_imm[11]}}, in_imm[11:0]});
  assign fits13 = (in_imm == {{19{in_imm[12]}}, in_imm[12:0]});
  assign fits21 = (in_imm == {{11{in_imm[20]}}, in_imm[20:0]});

  // Single-word encoder: format selection, bit scattering and error checks.
  always_comb begin
    enc_inst = 32'h0;
    enc_err  = 1'b0;
    case (in_opcode)
      OP_R: begin
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = !((in_funct7 == 7'h00) ||
                     ((in_funct7 == 7'h20) && ((in_funct3 == 3'd0) || (in_funct3 == 3'd5))));
      end
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = !fits12;
        case (in_opcode)
          OP_IMM: begin
            // Shift-immediates carry funct7 in imm[11:5]; only SRAI may use 0x20.
            if (in_funct3 == 3'd1)
              enc_err = enc_err | (in_imm[11:5] != 7'h00);
            else if (in_funct3 == 3'd5)
              enc_err = enc_err | ((in_imm[11:5] != 7'h00) && (in_imm[11:5] != 7'h20));
          end
          OP_LOAD:
            enc_err = enc_err | (in_funct3 == 3'd3) | (in_funct3 == 3'd6) | (in_funct3 == 3'd7);
          OP_JALR:
            enc_err = enc_err | (in_funct3 != 3'd0);
          OP_SYSTEM: begin
            // funct3 0 is ECALL/EBREAK: imm selects which, rd/rs1 must be x0.
            if (in_funct3 == 3'd4)
              enc_err = 1'b1;
            else if (in_funct3 == 3'd0)
              enc_err = enc_err | ((in_imm != 32'd0) && (in_imm != 32'd1)) |
                        (in_rd != 5'd0) | (in_rs1 != 5'd0);
          end
          default: ;
        endcase
      end
      OP_STORE: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = !fits12 || (in_funct3 > 3'd2);
      end
      OP_BRANCH: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = !fits13 || in_imm[0] || (in_funct3 == 3'd2) || (in_funct3 == 3'd3);
      end
      OP_LUI, OP_AUIPC: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = (in_imm[11:0] != 12'h0);
      end
      OP_JAL: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = !fits21 || in_imm[0];
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign enc_word = (ZERO_ON_ERROR && enc_err) ? 32'h0 : enc_inst;

`ifdef RV32I_ENCODER_LI_EXPAND_EN
  logic [31:0] addi_q, addi_d;
  logic [19:0] li_upper;
  logic [31:0] li_first;
  logic [31:0] li_addi;
  logic        li_two;

  // Rounding the upper part by imm[11] compensates for the sign-extended
  // low 12 bits that the following ADDI adds back.
  assign li_upper = in_imm[31:12] + {19'd0, in_imm[11]};
  assign li_addi  = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM};

  always_comb begin
    li_two = 1'b0;
    if (fits12) begin
      li_first = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM};
    end else if (in_imm[11:0] == 12'h0) begin
      li_first = {in_imm[31:12], in_rd, OP_LUI};
    end else begin
      li_first = {li_upper, in_rd, OP_LUI};
      li_two   = 1'b1;
    end
  end
`else
  logic unused_li;
  assign unused_li = in_li;
`endif

  always_comb begin
    state_d     = state_q;
    out_inst_d  = out_inst_q;
    out_error_d = out_error_q;
    out_last_d  = out_last_q;
`ifdef RV32I_ENCODER_LI_EXPAND_EN
    addi_d      = addi_q;
`endif
    case (state_q)
`ifdef RV32I_ENCODER_LI_EXPAND_EN
      LI_HI: begin
        if (out_ready) begin
          state_d     = HOLD;
          out_inst_d  = addi_q;
          out_error_d = 1'b0;
          out_last_d  = 1'b1;
        end
      end
`endif
      default: begin
        if (in_fire) begin
          state_d     = HOLD;
          out_inst_d  = enc_word;
          out_error_d = enc_err;
          out_last_d  = 1'b1;
`ifdef RV32I_ENCODER_LI_EXPAND_EN
          if (in_li) begin
            out_inst_d  = li_first;
            out_error_d = 1'b0;
            out_last_d  = !li_two;
            addi_d      = li_addi;
            if (li_two) state_d = LI_HI;
          end
`endif
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_inst_q  <= 32'h0;
      out_error_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef RV32I_ENCODER_LI_EXPAND_EN
      addi_q      <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      out_inst_q  <= out_inst_d;
      out_error_q <= out_error_d;
      out_last_q  <= out_last_d;
`ifdef RV32I_ENCODER_LI_EXPAND_EN
      addi_q      <= addi_d;
`endif
    end
  end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Testbench for rv32i_inst_encoder.
// The driver issues field bundles and pushes {inst, error, last} from a
// behavioural encoder model into exp_q. The monitor drives out_ready and
// pops and compares on every output handshake.
module tb_rv32i_inst_encoder;
  localparam int W = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_li;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_error;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int hold_cnt = 0;
  bit force_ready = 1'b0;

  rv32i_inst_encoder #(.ZERO_ON_ERROR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_li(in_li),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_error(out_error), .out_last(out_last)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input bit li);
    int s;
    int unsigned u, o, fd, fs1, fs2, ff3, ff7, w, hi, hi7;
    bit err;
    s = int'(imm); u = imm;
    o = 32'(op); fd = 32'(rd); fs1 = 32'(rs1); fs2 = 32'(rs2);
    ff3 = 32'(f3); ff7 = 32'(f7);
`ifdef RV32I_ENCODER_LI_EXPAND_EN
    if (li) begin
      if (s >= -2048 && s <= 2047) begin
        exp_q.push_back({32'(((u & 32'hFFF) << 20) | (fd << 7) | 32'h13), 1'b0, 1'b1});
      end else if (u % 4096 == 0) begin
        exp_q.push_back({32'(u | (fd << 7) | 32'h37), 1'b0, 1'b1});
      end else begin
        hi = (u + 32'h800) & 32'hFFFFF000;
        exp_q.push_back({32'(hi | (fd << 7) | 32'h37), 1'b0, 1'b0});
        exp_q.push_back({32'(((u & 32'hFFF) << 20) | (fd << 15) | (fd << 7) | 32'h13), 1'b0, 1'b1});
      end
      return;
    end
`endif
    err = 1'b0; w = 0;
    hi7 = (u >> 5) & 32'h7F;
    case (o)
      32'h33: begin
        w = (ff7 << 25) | (fs2 << 20) | (fs1 << 15) | (ff3 << 12) | (fd << 7) | o;
        err = !(ff7 == 0 || (ff7 == 32 && (ff3 == 0 || ff3 == 5)));
      end
      32'h13, 32'h03, 32'h67, 32'h73, 32'h0F: begin
        w = ((u & 32'hFFF) << 20) | (fs1 << 15) | (ff3 << 12) | (fd << 7) | o;
        err = !(s >= -2048 && s <= 2047);
        if (o == 32'h13 && ff3 == 1 && hi7 != 0) err = 1;
        if (o == 32'h13 && ff3 == 5 && hi7 != 0 && hi7 != 32) err = 1;
        if (o == 32'h03 && (ff3 == 3 || ff3 == 6 || ff3 == 7)) err = 1;
        if (o == 32'h67 && ff3 != 0) err = 1;
        if (o == 32'h73 && ff3 == 4) err = 1;
        if (o == 32'h73 && ff3 == 0 && (!(u == 0 || u == 1) || fd != 0 || fs1 != 0)) err = 1;
      end
      32'h23: begin
        w = (hi7 << 25) | (fs2 << 20) | (fs1 << 15) | (ff3 << 12) | ((u & 32'h1F) << 7) | o;
        err = !(s >= -2048 && s <= 2047) || ff3 > 2;
      end
      32'h63: begin
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (fs2 << 20) | (fs1 << 15) |
            (ff3 << 12) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | o;
        err = !(s >= -4096 && s <= 4095) || (u % 2 != 0) || ff3 == 2 || ff3 == 3;
      end
      32'h37, 32'h17: begin
        w = (u & 32'hFFFFF000) | (fd << 7) | o;
        err = (u % 4096 != 0);
      end
      32'h6F: begin
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 32'hFF) << 12) | (fd << 7) | o;
        err = !(s >= -1048576 && s <= 1048575) || (u % 2 != 0);
      end
      default: err = 1;
    endcase
    if (err) w = 0;
    exp_q.push_back({32'(w), err, 1'b1});
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input bit li);
    int budget;
    @(negedge clk);
    in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_li = li;
    in_valid = 1'b1;
    #1;
    budget = 0;
    while (!in_ready && budget < 300) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      in_valid = 1'b0;
      return;
    end
    model(op, f3, f7, rd, rs1, rs2, imm, li);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("valid_after_accept", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    int n;
    hold_cnt = 0;
    force_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] stall_word;
    logic [W-1:0] e;
    bit stall_seen;
    stall_seen = 1'b0;
    stall_word = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else if (force_ready) begin
        out_ready = 1'b1;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      #2;
      if (!rst && out_valid) begin
        if (stall_seen) chk("stable_while_stalled", 64'({out_inst, out_error, out_last}), 64'(stall_word));
        if (out_ready) begin
          stall_seen = 1'b0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word actual=%h required=none", {out_inst, out_error, out_last});
          end else begin
            e = exp_q.pop_front();
            chk("word", 64'({out_inst, out_error, out_last}), 64'(e));
          end
        end else begin
          chk("in_ready_low_while_stalled", 64'(in_ready), 64'd0);
          stall_seen = 1'b1;
          stall_word = {out_inst, out_error, out_last};
        end
      end else begin
        stall_seen = 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [6:0] ops [11];
    logic [6:0] op;
    logic [6:0] f7;
    logic [31:0] imm;
    int kind;
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_li = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_error", 64'(out_error), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    force_ready = 1'b1;

    // ADDI x1, x0, 5
    send(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    chk("addi_inst", 64'(out_inst), 64'h00500093);
    chk("addi_error", 64'(out_error), 64'd0);
    chk("addi_last", 64'(out_last), 64'd1);
    // SW x2, 8(x1)
    send(7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    chk("sw_inst", 64'(out_inst), 64'h0020A423);
    chk("sw_error", 64'(out_error), 64'd0);
    // BEQ with odd offset
    send(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    chk("beq_odd_error", 64'(out_error), 64'd1);
    chk("beq_odd_inst", 64'(out_inst), 64'd0);
    drain();

    // Backpressure: first word held three cycles, second must wait.
    hold_cnt = 4;
    force_ready = 1'b0;
    send(7'h33, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'd0, 1'b0);
    send(7'h37, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'hABCDE000, 1'b0);
    drain();

`ifdef RV32I_ENCODER_LI_EXPAND_EN
    send(7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 1'b1);
    chk("li_lui_inst", 64'(out_inst), 64'h123462B7);
    chk("li_lui_last", 64'(out_last), 64'd0);
    chk("li_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("li_addi_inst", 64'(out_inst), 64'hFFF28293);
    chk("li_addi_last", 64'(out_last), 64'd1);
    drain();

    // Reset right after the LUI handshake: the ADDI must never appear.
    send(7'h00, 3'd0, 7'h00, 5'd9, 5'd0, 5'd0, 32'h0000F123, 1'b1);
    @(posedge clk);
    #1;
    hold_cnt = 20;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("li_rst_out_valid", 64'(out_valid), 64'd0);
    chk("li_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    hold_cnt = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("li_rst_no_addi", 64'(out_valid), 64'd0);
    end
`endif

    // Reset while a single word is held drops it.
    hold_cnt = 10;
    send(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_drop_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    hold_cnt = 0;
    @(posedge clk);
    #1;
    chk("rst_drop_stays_idle", 64'(out_valid), 64'd0);

    // Randomized traffic with random backpressure.
    force_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 11) == 11) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      kind = $urandom_range(0, 6);
      case (kind)
        0: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        1: imm = 32'(int'($urandom_range(0, 16383)) - 8192);
        2: imm = ($urandom_range(0, 1) ? 32'h400 : 32'h0) | 32'($urandom_range(0, 31)) |
                 ($urandom_range(0, 5) == 0 ? 32'h20 : 32'h0);
        3: imm = $urandom & 32'hFFFFF000;
        4: imm = $urandom;
        5: imm = 32'(int'($urandom_range(0, 4194303)) - 2097152);
        default: imm = 32'($urandom_range(0, 1));
      endcase
      send(op, 3'($urandom_range(0, 7)), f7,
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
           5'($urandom), imm, ($urandom_range(0, 7) == 0));
    end
    drain();
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_inst_encoder.md
RV32I_INST_ENCODER -- requirements
Module: rv32i_inst_encoder

Interface
REQ-001 SHALL have parameter ZERO_ON_ERROR, default 1: 1 forces out_inst to 32'h0 when out_error is set.
REQ-002 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: field bundle valid.
REQ-005 SHALL have port in_ready, output, 1: encoder accepts bundle.
REQ-006 SHALL have ports in_opcode, input, 7; in_funct3, input, 3; in_funct7, input, 7: opcode and function fields.
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2, input, 5 each: register indices.
REQ-008 SHALL have port in_imm, input, 32: full-width immediate value, not pre-packed.
REQ-009 SHALL have port in_li, input, 1: load-immediate pseudo request; uses in_rd and in_imm only.
REQ-010 SHALL have port out_valid, output, 1: instruction word valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts word.
REQ-012 SHALL have ports out_inst, output, 32; out_error, output, 1; out_last, output, 1: encoded word, encode error, last word of sequence.

Function
REQ-013 SHALL transfer on in_valid&&in_ready and on out_valid&&out_ready; transfer at edge N gives out_valid at N+1; single-word throughput one per cycle.
REQ-014 SHALL hold out_inst/out_error/out_last stable while out_valid&&!out_ready.
REQ-015 SHALL drive in_ready = !rst && state==IDLE-capable && (!out_valid || out_ready).
REQ-016 SHALL select format by opcode: 0x23 S, 0x37/0x17 U, 0x6F J, 0x63 B, 0x33 R, 0x13/0x03/0x67/0x73/0x0F I; any other opcode sets out_error.
REQ-017 SHALL flag immediate range errors: I/S need in_imm == sext(in_imm[11:0]); B needs in_imm[0]==0 and in_imm == sext(in_imm[12:0]); J needs in_imm[0]==0 and in_imm == sext(in_imm[20:0]); U needs in_imm[11:0]==0.
REQ-018 SHALL flag field errors: R funct7 not 0x00/0x20, or 0x20 with funct3 not 0/5; shift-immediates (0x13, funct3 1/5) with in_imm[11:5] not 0x00, or 0x20 unless funct3==5; LOAD funct3 in {3,6,7}; STORE funct3 >2; BRANCH funct3 2/3; JALR funct3 !=0; SYSTEM funct3 4, or funct3 0 with in_imm not 0/1 or rd/rs1 nonzero.
REQ-019 SHALL ignore unused fields per format (e.g., rs2 for I-type) without error.
REQ-020 SHALL set out_last=1 for every non-LI word.
REQ-021 SHALL use states IDLE, HOLD (word pending), LI_HI (LUI sent, ADDI pending); LI_HI -> HOLD after LUI handshake.

Reset
REQ-022 SHALL on rst: out_valid=0, out_inst=0, out_error=0, out_last=0, state=IDLE, in_ready=0 while rst high.
REQ-023 SHALL abandon any pending or partial sequence on rst, emitting no further words from it.

Configuration
REQ-024 SHALL compile LI expansion only with macro RV32I_ENCODER_LI_EXPAND_EN defined.
REQ-025 SHALL with macro: imm fitting 12-bit signed -> one ADDI rd,x0,imm; imm[11:0]==0 -> one LUI rd,imm; else LUI rd,(imm+0x800)&0xFFFFF000 (out_last=0) then ADDI rd,rd,imm[11:0] (out_last=1), in_ready low until ADDI is accepted; never errors.
REQ-026 SHALL without macro ignore in_li entirely (normal encoding, state LI_HI absent).

Verification
REQ-027 SHALL test ADDI: opcode 0x13, f3 0, rd 1, rs1 0, imm 5 -> next cycle out_inst 0x00500093, error 0, last 1.
REQ-028 SHALL test SW: opcode 0x23, f3 2, rs1 1, rs2 2, imm 8 -> out_inst 0x0020A423, error 0.
REQ-029 SHALL test BEQ with imm 3 -> out_error 1, out_inst 0x00000000 (ZERO_ON_ERROR=1).
REQ-030 SHALL test (macro on) LI rd 5, imm 0x12345FFF -> 0x123462B7 last 0, then 0xFFF28293 last 1; in_ready low between.
REQ-031 SHALL test backpressure: out_ready low 3 cycles -> word stable, in_ready low, no loss or duplication after release.
REQ-032 SHALL test rst asserted one cycle after LUI of LI accepted -> out_valid 0 next cycle, ADDI never emitted.
